// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer with start/stall/halt/branch control and a carry register.
// Define RELATIVE_BRANCH_EN to make taken branches PC-relative (sign-extended TARGET[OFS_W-1:0]).
module pc_sequencer #(
    parameter int PC_W  = 10,
    parameter int OFS_W = 8
) (
    input  logic            CLK,
    input  logic            Reset,
    input  logic            START,
    input  logic [PC_W-1:0] START_ADDR,
    input  logic            BRANCH,
    input  logic            BR_FLAG,
    input  logic [PC_W-1:0] TARGET,
    input  logic            HALT,
    input  logic            STALL,
    input  logic            SC_OUT,
    input  logic            SC_WE,
    output logic            SC_IN,
    output logic [PC_W-1:0] PC,
    output logic            DONE
);
    typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

    localparam logic [PC_W-1:0] ONE = PC_W'(1);

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d, br_tgt;
    logic            sc_q, sc_d, done_q;

`ifdef RELATIVE_BRANCH_EN
    logic signed [OFS_W-1:0] ofs;
    assign ofs    = TARGET[OFS_W-1:0];
    assign br_tgt = pc_q + PC_W'(ofs);
`else
    assign br_tgt = TARGET;
`endif

    // Next-state logic: START restarts from any state; in RUN stall beats halt beats branch beats increment.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        sc_d    = sc_q;
        if (START) begin
            state_d = RUN;
            pc_d    = START_ADDR;
            sc_d    = 1'b0;
        end else if (state_q == RUN && !STALL) begin
            sc_d    = SC_WE ? SC_OUT : sc_q;
            state_d = HALT ? HALTED : RUN;
            pc_d    = HALT ? pc_q : (BRANCH && BR_FLAG) ? br_tgt : pc_q + ONE;
        end
    end

    // State, PC, carry and DONE registers; DONE is registered from the next state so it tracks HALTED.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            sc_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            sc_q    <= sc_d;
            done_q  <= (state_d == HALTED);
        end
    end

    assign PC    = pc_q;
    assign SC_IN = sc_q;
    assign DONE  = done_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed self-checking bench for pc_sequencer.
module tb_pc_sequencer;
    logic       CLK = 1'b0;
    logic       Reset = 1'b1;
    logic       START = 1'b0;
    logic [9:0] START_ADDR = '0;
    logic       BRANCH = 1'b0;
    logic       BR_FLAG = 1'b0;
    logic [9:0] TARGET = '0;
    logic       HALT = 1'b0;
    logic       STALL = 1'b0;
    logic       SC_OUT = 1'b0;
    logic       SC_WE = 1'b0;
    logic       SC_IN;
    logic [9:0] PC;
    logic       DONE;
    int checks = 0;
    int failures = 0;

    pc_sequencer #(.PC_W(10), .OFS_W(8)) dut (
        .CLK(CLK), .Reset(Reset), .START(START), .START_ADDR(START_ADDR),
        .BRANCH(BRANCH), .BR_FLAG(BR_FLAG), .TARGET(TARGET), .HALT(HALT),
        .STALL(STALL), .SC_OUT(SC_OUT), .SC_WE(SC_WE), .SC_IN(SC_IN),
        .PC(PC), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        START = 0; BRANCH = 0; BR_FLAG = 0; HALT = 0; STALL = 0; SC_WE = 0; SC_OUT = 0;
    endtask

    // Load a start address and move on to running from it.
    task automatic go(input logic [9:0] addr);
        clear_inputs();
        START = 1; START_ADDR = addr;
        tick();
        START = 0;
    endtask

    task automatic test_reset();
        Reset = 1;
        #2;
        checks++; if (PC !== 10'h000) begin failures++; $display("FAIL reset_pc got=%h exp=000", PC); end
        checks++; if (SC_IN !== 1'b0) begin failures++; $display("FAIL reset_sc got=%b exp=0", SC_IN); end
        checks++; if (DONE !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", DONE); end
        @(negedge CLK);
        Reset = 0;
        tick();
        tick();
        checks++; if (PC !== 10'h000) begin failures++; $display("FAIL idle_hold_pc got=%h exp=000", PC); end
    endtask

    task automatic test_sequential();
        go(10'h010);
        checks++; if (PC !== 10'h010) begin failures++; $display("FAIL seq0 got=%h exp=010", PC); end
        tick();
        checks++; if (PC !== 10'h011) begin failures++; $display("FAIL seq1 got=%h exp=011", PC); end
        tick();
        checks++; if (PC !== 10'h012) begin failures++; $display("FAIL seq2 got=%h exp=012", PC); end
        tick();
        checks++; if (PC !== 10'h013) begin failures++; $display("FAIL seq3 got=%h exp=013", PC); end
        checks++; if (SC_IN !== 1'b0 || DONE !== 1'b0) begin failures++; $display("FAIL seq_flags sc=%b done=%b exp=0,0", SC_IN, DONE); end
    endtask

    task automatic test_branch();
        go(10'h020);
        BRANCH = 1; BR_FLAG = 1;
`ifdef RELATIVE_BRANCH_EN
        TARGET = 10'h0FE;
        tick();
        checks++; if (PC !== 10'h01E) begin failures++; $display("FAIL br_taken got=%h exp=01E", PC); end
        BR_FLAG = 0;
        tick();
        checks++; if (PC !== 10'h01F) begin failures++; $display("FAIL br_not_taken got=%h exp=01F", PC); end
        BRANCH = 0; BR_FLAG = 1;
        tick();
        checks++; if (PC !== 10'h020) begin failures++; $display("FAIL brflag_only got=%h exp=020", PC); end
`else
        TARGET = 10'h0F0;
        tick();
        checks++; if (PC !== 10'h0F0) begin failures++; $display("FAIL br_taken got=%h exp=0F0", PC); end
        BR_FLAG = 0;
        tick();
        checks++; if (PC !== 10'h0F1) begin failures++; $display("FAIL br_not_taken got=%h exp=0F1", PC); end
        BRANCH = 0; BR_FLAG = 1;
        tick();
        checks++; if (PC !== 10'h0F2) begin failures++; $display("FAIL brflag_only got=%h exp=0F2", PC); end
`endif
        clear_inputs();
    endtask

    task automatic test_wrap();
        go(10'h3FF);
        tick();
        checks++; if (PC !== 10'h000) begin failures++; $display("FAIL wrap got=%h exp=000", PC); end
`ifdef RELATIVE_BRANCH_EN
        go(10'h3FE);
        BRANCH = 1; BR_FLAG = 1; TARGET = 10'h005;
        tick();
        checks++; if (PC !== 10'h003) begin failures++; $display("FAIL rel_wrap got=%h exp=003", PC); end
        clear_inputs();
`endif
    endtask

    task automatic test_stall_halt();
        go(10'h030);
        STALL = 1; SC_WE = 1; SC_OUT = 1; HALT = 1;
        tick();
        tick();
        checks++; if (PC !== 10'h030) begin failures++; $display("FAIL stall_pc got=%h exp=030", PC); end
        checks++; if (SC_IN !== 1'b0) begin failures++; $display("FAIL stall_sc got=%b exp=0", SC_IN); end
        checks++; if (DONE !== 1'b0) begin failures++; $display("FAIL stall_done got=%b exp=0", DONE); end
        STALL = 0;
        tick();
        checks++; if (PC !== 10'h030 || SC_IN !== 1'b1 || DONE !== 1'b1) begin failures++; $display("FAIL halt_release pc=%h sc=%b done=%b exp=030,1,1", PC, SC_IN, DONE); end
        HALT = 0; SC_WE = 0; STALL = 1;
        tick();
        STALL = 0;
        tick();
        checks++; if (PC !== 10'h030 || DONE !== 1'b1) begin failures++; $display("FAIL halted_hold pc=%h done=%b exp=030,1", PC, DONE); end
    endtask

    task automatic test_halted_restart();
        go(10'h042);
        HALT = 1; SC_WE = 1; SC_OUT = 1;
        tick();
        clear_inputs();
        checks++; if (PC !== 10'h042 || SC_IN !== 1'b1 || DONE !== 1'b1) begin failures++; $display("FAIL halt_at_042 pc=%h sc=%b done=%b exp=042,1,1", PC, SC_IN, DONE); end
        go(10'h100);
        checks++; if (PC !== 10'h100 || SC_IN !== 1'b0 || DONE !== 1'b0) begin failures++; $display("FAIL halted_restart pc=%h sc=%b done=%b exp=100,0,0", PC, SC_IN, DONE); end
        tick();
        checks++; if (PC !== 10'h101) begin failures++; $display("FAIL restart_runs got=%h exp=101", PC); end
    endtask

    task automatic test_halt_vs_branch();
        go(10'h060);
        HALT = 1; BRANCH = 1; BR_FLAG = 1; TARGET = 10'h0AA;
        tick();
        clear_inputs();
        checks++; if (PC !== 10'h060 || DONE !== 1'b1) begin failures++; $display("FAIL halt_wins pc=%h done=%b exp=060,1", PC, DONE); end
    endtask

    task automatic test_back_to_back();
        go(10'h070);
        SC_WE = 1; SC_OUT = 1;
        tick();
        SC_WE = 0; SC_OUT = 0;
        tick();
        checks++; if (PC !== 10'h072 || SC_IN !== 1'b1) begin failures++; $display("FAIL sc_hold pc=%h sc=%b exp=072,1", PC, SC_IN); end
        START = 1; START_ADDR = 10'h200; SC_WE = 1; SC_OUT = 1; HALT = 1;
        tick();
        clear_inputs();
        checks++; if (PC !== 10'h200 || SC_IN !== 1'b0 || DONE !== 1'b0) begin failures++; $display("FAIL run_restart pc=%h sc=%b done=%b exp=200,0,0", PC, SC_IN, DONE); end
    endtask

    task automatic test_async_reset();
        go(10'h055);
        SC_WE = 1; SC_OUT = 1;
        tick();
        SC_WE = 0;
        #2 Reset = 1;
        #1;
        checks++; if (PC !== 10'h000 || SC_IN !== 1'b0 || DONE !== 1'b0) begin failures++; $display("FAIL async_reset pc=%h sc=%b done=%b exp=000,0,0", PC, SC_IN, DONE); end
        #1 Reset = 0;
        tick();
        checks++; if (PC !== 10'h000) begin failures++; $display("FAIL post_reset_idle got=%h exp=000", PC); end
        go(10'h077);
        checks++; if (PC !== 10'h077 || DONE !== 1'b0) begin failures++; $display("FAIL post_reset_start pc=%h done=%b exp=077,0", PC, DONE); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_wrap();
        test_stall_halt();
        test_halted_restart();
        test_halt_vs_branch();
        test_back_to_back();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
